// File: rtl/moravec_scan_sequencer.sv
// Load/scan controller for an N x N alternate-edge-write image RAM. Streams an image in, then
// scores every interior pixel with a single-pixel Moravec window and emits one corner flag each.
module moravec_scan_sequencer #(
    parameter int unsigned N       = 8,
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned THRESH  = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pix_valid,
    input  logic [PIXEL_W-1:0] pix_data,
    output logic               pix_ready,
    output logic               ram_we,
    output logic               ram_harris_bit,
    output logic [ADDR_W-1:0]  ram_primary_address,
    output logic [ADDR_W-1:0]  ram_dual_address,
    output logic [PIXEL_W-1:0] ram_data_in,
    input  logic [PIXEL_W-1:0] ram_primary_output,
    input  logic [PIXEL_W-1:0] ram_dual_output,
    output logic               corner_we,
    output logic [ADDR_W-1:0]  corner_addr,
    output logic               corner_bit,
    output logic [ADDR_W-1:0]  corner_count,
    output logic               busy,
    output logic               done
);

    localparam int unsigned SqW = 2 * PIXEL_W;
    localparam logic [SqW-1:0]    Thresh  = SqW'(THRESH);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N * N - 1);
    localparam logic [ADDR_W-1:0] LastRc  = ADDR_W'(N - 2);
    localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] One     = ADDR_W'(1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StRdE, StRdS, StRdSe, StRdSw, StDecide, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   load_idx_q, load_idx_d;
    logic                hold_q, hold_d;
    logic [PIXEL_W-1:0]  data_q, data_d;
    logic [ADDR_W-1:0]   r_q, r_d, c_q, c_d;
    logic [SqW-1:0]      min_sq_q, min_sq_d;
    logic [ADDR_W-1:0]   corner_addr_q, corner_addr_d;
    logic                corner_bit_q, corner_bit_d;
    logic [ADDR_W-1:0]   corner_count_q, corner_count_d;

    logic [ADDR_W-1:0]   pix_addr;
    logic [PIXEL_W-1:0]  diff;
    logic [SqW-1:0]      sq, min_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            load_idx_q     <= '0;
            hold_q         <= 1'b0;
            data_q         <= '0;
            r_q            <= '0;
            c_q            <= '0;
            min_sq_q       <= '0;
            corner_addr_q  <= '0;
            corner_bit_q   <= 1'b0;
            corner_count_q <= '0;
        end else begin
            state_q        <= state_d;
            load_idx_q     <= load_idx_d;
            hold_q         <= hold_d;
            data_q         <= data_d;
            r_q            <= r_d;
            c_q            <= c_d;
            min_sq_q       <= min_sq_d;
            corner_addr_q  <= corner_addr_d;
            corner_bit_q   <= corner_bit_d;
            corner_count_q <= corner_count_d;
        end
    end

    always_comb begin
        pix_addr = r_q * RowStep + c_q;
        diff     = (ram_primary_output > ram_dual_output) ? ram_primary_output - ram_dual_output
                                                          : ram_dual_output - ram_primary_output;
        sq       = SqW'(diff) * SqW'(diff);
        min_next = (sq < min_sq_q) ? sq : min_sq_q;
    end

    always_comb begin
        state_d             = state_q;
        load_idx_d          = load_idx_q;
        hold_d              = hold_q;
        data_d              = data_q;
        r_d                 = r_q;
        c_d                 = c_q;
        min_sq_d            = min_sq_q;
        corner_addr_d       = corner_addr_q;
        corner_bit_d        = corner_bit_q;
        corner_count_d      = corner_count_q;
        pix_ready           = 1'b0;
        ram_we              = 1'b0;
        ram_primary_address = '0;
        ram_dual_address    = '0;
        ram_data_in         = data_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d        = StLoad;
                    load_idx_d     = '0;
                    hold_d         = 1'b0;
                    corner_count_d = '0;
                end
            end
            StLoad: begin
                // Each write spans the accept cycle plus the hold cycle: two edges with identical
                // we/address/data, so exactly one lands on the RAM's accepting phase.
                ram_primary_address = load_idx_q;
                if (!hold_q) begin
                    pix_ready   = 1'b1;
                    ram_data_in = pix_data;
                    if (pix_valid) begin
                        ram_we = 1'b1;
                        data_d = pix_data;
                        hold_d = 1'b1;
                    end
                end else begin
                    ram_we = 1'b1;
                    hold_d = 1'b0;
                    if (load_idx_q == LastIdx) begin
                        state_d  = StRdE;
                        r_d      = One;
                        c_d      = One;
                        min_sq_d = '1;
                    end else begin
                        load_idx_d = load_idx_q + One;
                    end
                end
            end
            StRdE: begin
                ram_primary_address = pix_addr;
                ram_dual_address    = pix_addr + One;
                min_sq_d            = min_next;
                state_d             = StRdS;
            end
            StRdS: begin
                ram_primary_address = pix_addr;
                ram_dual_address    = pix_addr + RowStep;
                min_sq_d            = min_next;
                state_d             = StRdSe;
            end
            StRdSe: begin
                ram_primary_address = pix_addr;
                ram_dual_address    = pix_addr + RowStep + One;
                min_sq_d            = min_next;
                state_d             = StRdSw;
            end
            StRdSw: begin
                // Final minimum is known here, so the strobe data is registered for DECIDE.
                ram_primary_address = pix_addr;
                ram_dual_address    = pix_addr + RowStep - One;
                min_sq_d            = min_next;
                corner_addr_d       = pix_addr;
                corner_bit_d        = (min_next > Thresh);
                if (min_next > Thresh) begin
                    corner_count_d = corner_count_q + One;
                end
                state_d = StDecide;
            end
            StDecide: begin
                if (c_q == LastRc) begin
                    c_d = One;
                    if (r_q == LastRc) begin
                        state_d = StDone;
                    end else begin
                        r_d      = r_q + One;
                        state_d  = StRdE;
                        min_sq_d = '1;
                    end
                end else begin
                    c_d      = c_q + One;
                    state_d  = StRdE;
                    min_sq_d = '1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ram_harris_bit = 1'b0;
    assign corner_we      = (state_q == StDecide);
    assign corner_addr    = corner_addr_q;
    assign corner_bit     = corner_bit_q;
    assign corner_count   = corner_count_q;
    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StDone);

endmodule

// File: tb/tb_moravec_scan_sequencer.sv
// Bench for moravec_scan_sequencer: alternate-edge RAM model plus an arithmetic corner model
// computed directly from the image array.
module tb_moravec_scan_sequencer;

    localparam int N    = 8;
    localparam int PW   = 8;
    localparam int AW   = 7;
    localparam int THR  = 100;
    localparam int NPIX = N * N;
    localparam int NINT = (N - 2) * (N - 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic          pix_ready, ram_we, ram_harris_bit;
    logic [AW-1:0] ram_primary_address, ram_dual_address;
    logic [PW-1:0] ram_data_in, ram_primary_output, ram_dual_output;
    logic          corner_we, corner_bit, busy, done;
    logic [AW-1:0] corner_addr, corner_count;

    always #5 clk = ~clk;

    moravec_scan_sequencer #(.N(N), .PIXEL_W(PW), .ADDR_W(AW), .THRESH(THR)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .pix_valid           (pix_valid),
        .pix_data            (pix_data),
        .pix_ready           (pix_ready),
        .ram_we              (ram_we),
        .ram_harris_bit      (ram_harris_bit),
        .ram_primary_address (ram_primary_address),
        .ram_dual_address    (ram_dual_address),
        .ram_data_in         (ram_data_in),
        .ram_primary_output  (ram_primary_output),
        .ram_dual_output     (ram_dual_output),
        .corner_we           (corner_we),
        .corner_addr         (corner_addr),
        .corner_bit          (corner_bit),
        .corner_count        (corner_count),
        .busy                (busy),
        .done                (done)
    );

    // RAM model: no reset, writes land only on every other edge; phase_sel picks which.
    logic [PW-1:0] mem [0:127];
    logic [31:0]   edge_cnt = 0;
    bit            phase_sel = 1'b0;
    bit            scramble = 1'b0;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (scramble) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'($urandom);
        end else if (ram_we && (edge_cnt[0] ^ phase_sel)) begin
            mem[ram_primary_address] <= ram_data_in;
        end
    end

    assign ram_primary_output = mem[ram_primary_address];
    assign ram_dual_output    = mem[ram_dual_address];

    logic [42:0] outs_v;
    assign outs_v = {pix_ready, ram_we, ram_harris_bit, ram_primary_address, ram_dual_address,
                     ram_data_in, corner_we, corner_addr, corner_bit, corner_count, busy, done};

    int total = 0;
    int bad = 0;
    int img [NPIX];
    int exp_addr [$];
    int exp_bit [$];
    int exp_count;
    logic [AW-1:0] obs_addr [$];
    logic          obs_bit [$];
    int done_cyc, accepted, we_cycles, ready_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int sqd(input int a, input int b);
        return (a - b) * (a - b);
    endfunction

    task automatic build_expected();
        int p, m;
        exp_addr.delete();
        exp_bit.delete();
        exp_count = 0;
        for (int r = 1; r <= N - 2; r++) begin
            for (int c = 1; c <= N - 2; c++) begin
                p = img[r*N+c];
                m = sqd(p, img[r*N+c+1]);
                if (sqd(p, img[(r+1)*N+c]) < m)   m = sqd(p, img[(r+1)*N+c]);
                if (sqd(p, img[(r+1)*N+c+1]) < m) m = sqd(p, img[(r+1)*N+c+1]);
                if (sqd(p, img[(r+1)*N+c-1]) < m) m = sqd(p, img[(r+1)*N+c-1]);
                exp_addr.push_back(r * N + c);
                exp_bit.push_back(m > THR ? 1 : 0);
                if (m > THR) exp_count++;
            end
        end
    endtask

    task automatic do_scramble();
        scramble = 1'b1;
        @(posedge clk); #1;
        scramble = 1'b0;
    endtask

    // One full frame from the start pulse; cyc counts cycles after the start edge.
    task automatic run_frame(input bit gaps, input bit extra_start);
        int  idx, cyc;
        bit  seen_done, acc;
        obs_addr.delete();
        obs_bit.delete();
        done_cyc = -1; accepted = 0; we_cycles = 0; ready_bad = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; cyc = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 2000) begin
            if (idx < NPIX) begin
                pix_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                pix_data  = 8'(img[idx]);
            end else begin
                pix_valid = 1'($urandom_range(0, 1));
                pix_data  = 8'($urandom);
            end
            if (extra_start && cyc == 40) start = 1'b1;
            @(negedge clk);
            if (corner_we) begin
                obs_addr.push_back(corner_addr);
                obs_bit.push_back(corner_bit);
            end
            if (done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
            end
            if (ram_we) we_cycles++;
            if (!gaps && cyc < 2 * NPIX && pix_ready !== ((cyc % 2) == 0)) ready_bad++;
            acc = pix_ready && pix_valid;
            if (acc) accepted++;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) idx++;
            cyc++;
        end
        pix_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input bit gaps);
        build_expected();
        chk("strobe_count", 64'(obs_addr.size()), 64'(NINT));
        for (int i = 0; i < NINT; i++) begin
            chk($sformatf("corner_addr[%0d]", i),
                (i < obs_addr.size()) ? 64'(obs_addr[i]) : '1, 64'(exp_addr[i]));
            chk($sformatf("corner_bit[%0d]", i),
                (i < obs_bit.size()) ? 64'(obs_bit[i]) : '1, 64'(exp_bit[i]));
        end
        chk("corner_count", 64'(corner_count), 64'(exp_count));
        chk("pixels_accepted", 64'(accepted), 64'(NPIX));
        chk("ram_we_cycles", 64'(we_cycles), 64'(2 * NPIX));
        chk("ram_contents", 64'(ram_mismatches()), 64'd0);
        if (!gaps) begin
            chk("done_latency", 64'(done_cyc), 64'(2 * NPIX + 5 * NINT));
            chk("ready_alternates", 64'(ready_bad), 64'd0);
        end else begin
            chk("done_seen", 64'(done_cyc >= 0), 64'd1);
        end
    endtask

    function automatic int ram_mismatches();
        int n = 0;
        for (int i = 0; i < NPIX; i++) if (mem[i] !== 8'(img[i])) n++;
        return n;
    endfunction

    task automatic set_spot();
        for (int i = 0; i < NPIX; i++) img[i] = 0;
        img[3*N+3] = 200;
    endtask

    initial begin
        // 1: reset with random inputs, then idle without start
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom); pix_valid = 1'($urandom); pix_data = 8'($urandom);
            @(negedge clk);
            chk("reset_outputs", 64'(outs_v), 64'd0);
        end
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        do_scramble();
        for (int i = 0; i < 20; i++) begin
            pix_valid = 1'($urandom); pix_data = 8'($urandom);
            @(negedge clk);
            chk("idle_outputs", 64'(outs_v), 64'd0);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;

        // 2: index image, both RAM write phases
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < NPIX; i++) img[i] = i;
            phase_sel = 1'(ph);
            do_scramble();
            run_frame(1'b0, 1'b0);
            check_frame(1'b0);
        end

        // 3: flat image
        for (int i = 0; i < NPIX; i++) img[i] = 50;
        do_scramble();
        run_frame(1'b0, 1'b0);
        check_frame(1'b0);
        chk("flat_count_zero", 64'(corner_count), 64'd0);

        // 4: single bright pixel
        set_spot();
        do_scramble();
        run_frame(1'b0, 1'b0);
        check_frame(1'b0);
        chk("spot_count_one", 64'(corner_count), 64'd1);

        // 5: same image, random valid gaps and a stray start mid-load
        phase_sel = 1'($urandom);
        do_scramble();
        run_frame(1'b1, 1'b1);
        check_frame(1'b1);
        chk("gap_count_one", 64'(corner_count), 64'd1);

        // 6: reset during RD_SE of pixel (4,4), then a clean frame
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
        do_scramble();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int idx = 0;
            for (int cyc = 0; cyc <= 2 * NPIX + 5 * 21 + 2; cyc++) begin
                pix_valid = (idx < NPIX);
                pix_data  = 8'(img[idx % NPIX]);
                @(negedge clk);
                if (cyc == 2 * NPIX + 5 * 21 + 2) break;
                if (pix_ready && pix_valid) idx++;
                @(posedge clk); #1;
            end
        end
        chk("abort_primary_addr", 64'(ram_primary_address), 64'(4 * N + 4));
        chk("abort_dual_addr", 64'(ram_dual_address), 64'(5 * N + 5));
        rst = 1'b1;
        #1;
        chk("abort_ram_we", 64'(ram_we), 64'd0);
        chk("abort_corner_we", 64'(corner_we), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        pix_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_outputs", 64'(outs_v), 64'd0);
        set_spot();
        do_scramble();
        run_frame(1'b0, 1'b0);
        check_frame(1'b0);
        chk("restart_count_one", 64'(corner_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
